sna_resp_flit_boxer: RTL and testbench

SNA_RESP_FLIT_BOXER -- requirements
Module: sna_resp_flit_boxer

---
 rtl/mna_noc_pkg.sv | 43 ++++
 rtl/sna_resp_rr_arb.sv | 37 +++
 rtl/sna_resp_flit_boxer.sv | 121 ++++++++++++
 tb/tb_sna_resp_flit_boxer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mna_noc_pkg.sv
// Shared NoC definitions for the SNA response flit boxer.
//   FLIT_W          : flit width (37 bits)
//   FLIT_HEAD/PAYLOAD : flit type codes carried in bits [36:35]
//   *_HI / *_LO     : field bit positions for header and payload flits
//   state_t         : boxer FSM encoding (IDLE, HEAD, BODY)
//   ARB_RD / ARB_WR : requester indices on the response arbiter
package mna_noc_pkg;

  localparam int unsigned FLIT_W = 37;

  localparam logic [1:0] FLIT_HEAD    = 2'b10;
  localparam logic [1:0] FLIT_PAYLOAD = 2'b01;

  // Common type field
  localparam int unsigned TYPE_HI = 36;
  localparam int unsigned TYPE_LO = 35;

  // Header fields
  localparam int unsigned DEST_HI     = 34;
  localparam int unsigned DEST_LO     = 31;
  localparam int unsigned SRC_HI      = 30;
  localparam int unsigned SRC_LO      = 27;
  localparam int unsigned HDR_PAR_BIT = 26;
  localparam int unsigned RESP_HI     = 2;
  localparam int unsigned RESP_LO     = 1;
  localparam int unsigned WR_BIT      = 0;

  // Payload fields
  localparam int unsigned PAY_PAR_BIT = 34;
  localparam int unsigned DATA_HI     = 31;
  localparam int unsigned DATA_LO     = 0;

  // Arbiter requester indices
  localparam int unsigned ARB_RD = 0;
  localparam int unsigned ARB_WR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } state_t;

endpackage

// File: rtl/sna_resp_rr_arb.sv
// Two-requester round-robin arbiter for read/write responses.
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector, [ARB_RD] = read, [ARB_WR] = write
//   advance  : grant was taken this cycle; move the pointer
//   gnt      : one-hot grant (combinational from req)
// After reset the write requester wins a tie. A lone requester always wins.
module sna_resp_rr_arb
  import mna_noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic favour_wr_q;

  always_comb begin
    gnt = 2'b00;
    if (req[ARB_WR] && (!req[ARB_RD] || favour_wr_q)) begin
      gnt[ARB_WR] = 1'b1;
    end else if (req[ARB_RD]) begin
      gnt[ARB_RD] = 1'b1;
    end
  end

  // Favour whichever source was not served by the last accepted grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      favour_wr_q <= 1'b1;
    end else if (advance) begin
      favour_wr_q <= gnt[ARB_RD];
    end
  end

endmodule

// File: rtl/sna_resp_flit_boxer.sv
// Packs AXI4-Lite read/write responses into two-flit NoC packets
// (header then payload).
//   Parameters : SRC_ID (node ID in header), DEST_W (dest_id width)
//   clk, rst   : clock, synchronous active-high reset
//   rvalid/rready/rdata/rresp : AXI4-Lite read response channel
//   bvalid/bready/bresp       : AXI4-Lite write response channel
//   dest_id    : requesting node, captured with the accepted response
//   noc_data/noc_valid/noc_ready : outgoing flit stream
// Optional feature: define SNA_RESP_BOXER_PARITY_EN to place even parity in
// header bit [26] (over [25:0]) and payload bit [34] (over [31:0]).
module sna_resp_flit_boxer
  import mna_noc_pkg::*;
#(
  parameter logic [3:0]  SRC_ID = 4'h0,
  parameter int unsigned DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [DEST_W-1:0] dest_id,
  output logic [36:0]       noc_data,
  output logic              noc_valid,
  input  logic              noc_ready
);

  state_t state_q, state_d;

  logic [1:0]        req, gnt;
  logic              accept;
  logic              wr_q;
  logic [1:0]        resp_q;
  logic [31:0]       data_q;
  logic [DEST_W-1:0] dest_q;
  logic [3:0]        dest4;
  logic [FLIT_W-1:0] header, payload;

  assign req = {bvalid, rvalid};

  sna_resp_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign dest4 = 4'(dest_q);

  always_comb begin
    header                   = '0;
    header[TYPE_HI:TYPE_LO]  = FLIT_HEAD;
    header[DEST_HI:DEST_LO]  = dest4;
    header[SRC_HI:SRC_LO]    = SRC_ID;
    header[RESP_HI:RESP_LO]  = resp_q;
    header[WR_BIT]           = wr_q;
    payload                  = '0;
    payload[TYPE_HI:TYPE_LO] = FLIT_PAYLOAD;
    payload[DATA_HI:DATA_LO] = data_q;
`ifdef SNA_RESP_BOXER_PARITY_EN
    header[HDR_PAR_BIT]      = ^header[HDR_PAR_BIT-1:0];
    payload[PAY_PAR_BIT]     = ^payload[DATA_HI:DATA_LO];
`endif
  end

  // All outputs are forced low during reset, so a response abandoned in
  // HEAD/BODY never shows a partial flit.
  always_comb begin
    state_d   = state_q;
    rready    = 1'b0;
    bready    = 1'b0;
    noc_valid = 1'b0;
    noc_data  = '0;
    accept    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          rready = gnt[ARB_RD];
          bready = gnt[ARB_WR];
          accept = |gnt;
          if (accept) state_d = ST_HEAD;
        end
        ST_HEAD: begin
          noc_valid = 1'b1;
          noc_data  = header;
          if (noc_ready) state_d = ST_BODY;
        end
        ST_BODY: begin
          noc_valid = 1'b1;
          noc_data  = payload;
          if (noc_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      resp_q  <= '0;
      data_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q   <= gnt[ARB_WR];
        resp_q <= gnt[ARB_WR] ? bresp : rresp;
        data_q <= gnt[ARB_WR] ? {30'b0, bresp} : rdata;
        dest_q <= dest_id;
      end
    end
  end

endmodule

// File: tb/tb_sna_resp_flit_boxer.sv
module tb_sna_resp_flit_boxer;

  localparam logic [3:0] SRC = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rvalid, rready, bvalid, bready, noc_valid, noc_ready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [3:0]  dest_id;
  logic [36:0] noc_data;

  int checks = 0;
  int errors = 0;
  bit favour_wr = 1'b1;

  always #5 clk = ~clk;

  sna_resp_flit_boxer #(.SRC_ID(SRC), .DEST_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .dest_id   (dest_id),
    .noc_data  (noc_data),
    .noc_valid (noc_valid),
    .noc_ready (noc_ready)
  );

  // Reference flit construction, arithmetic on field weights.
  function automatic logic [36:0] exp_head(bit wr, logic [1:0] resp, logic [3:0] dest);
    logic [36:0] v;
    v = (37'd2 << 35) + (37'(dest) << 31) + (37'(SRC) << 27) + (37'(resp) << 1) + 37'(wr);
`ifdef SNA_RESP_BOXER_PARITY_EN
    if ((($countones(resp) + int'(wr)) % 2) == 1) v = v + (37'd1 << 26);
`endif
    return v;
  endfunction

  function automatic logic [36:0] exp_pay(logic [31:0] data);
    logic [36:0] v;
    v = (37'd1 << 35) + 37'(data);
`ifdef SNA_RESP_BOXER_PARITY_EN
    if (($countones(data) % 2) == 1) v = v + (37'd1 << 34);
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects the next two transferred flits; noc_ready is random when
  // stall_max > 0. ok = 0 if the flits do not appear within the budget.
  task automatic drain(input int stall_max, output logic [36:0] f0,
                       output logic [36:0] f1, output bit ok);
    int n;
    n  = 0;
    f0 = '0;
    f1 = '0;
    ok = 1'b0;
    for (int c = 0; c < 200 && n < 2; c++) begin
      noc_ready = (stall_max == 0) ? 1'b1 : ($urandom_range(0, stall_max) == 0);
      #1;
      if (noc_valid && noc_ready) begin
        if (n == 0) f0 = noc_data;
        else        f1 = noc_data;
        n++;
      end
      @(posedge clk);
      #1;
    end
    noc_ready = 1'b0;
    ok = (n == 2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rvalid = 1'b1; bvalid = 1'b1; noc_ready = 1'b1;
    rdata = 32'h1234_5678; rresp = 2'b00; bresp = 2'b00; dest_id = 4'h0;
    tick(); tick();
    #1;
    checks++;
    if (rready !== 1'b0 || bready !== 1'b0 || noc_valid !== 1'b0 || noc_data !== 37'b0) begin
      errors++;
      $display("FAIL reset: rready=%b bready=%b noc_valid=%b noc_data=%h, want all 0",
               rready, bready, noc_valid, noc_data);
    end
    rvalid = 1'b0; bvalid = 1'b0; noc_ready = 1'b0;
    tick();
    rst = 1'b0;
    favour_wr = 1'b1;
    tick();
    checks++;
    if (noc_valid !== 1'b0 || noc_data !== 37'b0) begin
      errors++;
      $display("FAIL idle_after_reset: noc_valid=%b noc_data=%h, want 0/0", noc_valid, noc_data);
    end
  endtask

  task automatic test_tie_rr();
    logic [36:0] f0, f1;
    bit ok, exp_wr;
    for (int i = 0; i < 4; i++) begin
      exp_wr  = (i % 2 == 0);
      rdata   = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
      dest_id = 4'($urandom);
      rvalid  = 1'b1; bvalid = 1'b1;
      #1;
      checks++;
      if (bready !== exp_wr || rready !== !exp_wr) begin
        errors++;
        $display("FAIL tie_grant[%0d]: bready=%b rready=%b, want %b/%b",
                 i, bready, rready, exp_wr, !exp_wr);
      end
      tick();
      favour_wr = !exp_wr;
      rvalid = 1'b0; bvalid = 1'b0;
      drain(0, f0, f1, ok);
      checks++;
      if (!ok || f0 !== exp_head(exp_wr, exp_wr ? bresp : rresp, dest_id) ||
          f1 !== exp_pay(exp_wr ? {30'b0, bresp} : rdata)) begin
        errors++;
        $display("FAIL tie_flits[%0d]: ok=%b got %h/%h, want %h/%h", i, ok, f0, f1,
                 exp_head(exp_wr, exp_wr ? bresp : rresp, dest_id),
                 exp_pay(exp_wr ? {30'b0, bresp} : rdata));
      end
    end
  endtask

  task automatic test_read_latency();
    rdata = 32'hDEADBEEF; rresp = 2'b00; dest_id = 4'h3; rvalid = 1'b1;
    #1;
    checks++;
    if (rready !== 1'b1 || bready !== 1'b0) begin
      errors++;
      $display("FAIL read_ready: rready=%b bready=%b, want 1/0", rready, bready);
    end
    tick();
    favour_wr = 1'b1;
    rvalid = 1'b0; noc_ready = 1'b1;
    #1;
    checks++;
    if (noc_valid !== 1'b1 || noc_data !== exp_head(1'b0, 2'b00, 4'h3)) begin
      errors++;
      $display("FAIL read_header: valid=%b data=%h, want 1/%h", noc_valid, noc_data,
               exp_head(1'b0, 2'b00, 4'h3));
    end
    tick();
    checks++;
    if (noc_valid !== 1'b1 || noc_data !== {2'b01, 3'b000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL read_payload: valid=%b data=%h, want 1/%h", noc_valid, noc_data,
               {2'b01, 3'b000, 32'hDEADBEEF});
    end
    tick();
    noc_ready = 1'b0;
    checks++;
    if (noc_valid !== 1'b0 || noc_data !== 37'b0) begin
      errors++;
      $display("FAIL read_done: valid=%b data=%h, want 0/0", noc_valid, noc_data);
    end
  endtask

  task automatic test_write();
    logic [36:0] f0, f1;
    bit ok;
    bresp = 2'b10; dest_id = 4'h5; bvalid = 1'b1;
    #1;
    tick();
    favour_wr = 1'b0;
    bvalid = 1'b0;
    drain(0, f0, f1, ok);
    checks++;
    if (!ok || f0[2:0] !== 3'b101 || f0[34:31] !== 4'h5 || f0[36:35] !== 2'b10 ||
        f0 !== exp_head(1'b1, 2'b10, 4'h5)) begin
      errors++;
      $display("FAIL write_header: ok=%b got %h, want %h", ok, f0, exp_head(1'b1, 2'b10, 4'h5));
    end
    checks++;
    if (f1[31:0] !== 32'h0000_0002 || f1 !== exp_pay(32'h2)) begin
      errors++;
      $display("FAIL write_payload: got %h, want %h", f1, exp_pay(32'h2));
    end
  endtask

  task automatic test_stall();
    logic [36:0] eh, ep;
    int xfers;
    bit bad;
    rdata = $urandom; rresp = 2'b01; dest_id = 4'hA;
    rvalid = 1'b1; bvalid = 1'b0; noc_ready = 1'b0;
    #1;
    tick();
    favour_wr = 1'b1;
    eh = exp_head(1'b0, 2'b01, 4'hA);
    ep = exp_pay(rdata);
    rvalid = 1'b1; bvalid = 1'b1;
    xfers = 0;
    bad = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 5; c++) begin
        noc_ready = 1'b0;
        #1;
        if (noc_valid !== 1'b1 || noc_data !== (ph == 0 ? eh : ep) ||
            rready !== 1'b0 || bready !== 1'b0) bad = 1'b1;
        tick();
      end
      noc_ready = 1'b1;
      #1;
      if (noc_valid && noc_data === (ph == 0 ? eh : ep)) xfers++;
      tick();
    end
    rvalid = 1'b0; bvalid = 1'b0; noc_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (noc_valid) xfers++;
      tick();
    end
    noc_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold: flit or ready changed during stall, want %h then %h held", eh, ep);
    end
    checks++;
    if (xfers != 2) begin
      errors++;
      $display("FAIL stall_count: transfers=%0d, want 2", xfers);
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] f0, f1;
    bit ok;
    rdata = $urandom; rresp = 2'b11; dest_id = 4'h7; rvalid = 1'b1; noc_ready = 1'b1;
    #1;
    tick();
    rvalid = 1'b0;
    tick();
    rst = 1'b1; noc_ready = 1'b0;
    tick();
    rst = 1'b0;
    favour_wr = 1'b1;
    #1;
    checks++;
    if (noc_valid !== 1'b0 || noc_data !== 37'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: valid=%b data=%h, want 0/0", noc_valid, noc_data);
    end
    rdata = $urandom; rresp = 2'b00; dest_id = 4'h9; rvalid = 1'b1;
    #1;
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle: rready=%b, want 1", rready);
    end
    tick();
    rvalid = 1'b0;
    drain(0, f0, f1, ok);
    checks++;
    if (!ok || f0 !== exp_head(1'b0, 2'b00, 4'h9) || f1 !== exp_pay(rdata)) begin
      errors++;
      $display("FAIL reset_mid_pair: ok=%b got %h/%h, want %h/%h", ok, f0, f1,
               exp_head(1'b0, 2'b00, 4'h9), exp_pay(rdata));
    end
  endtask

  task automatic test_parity();
    logic [36:0] f0, f1;
    bit ok;
    logic exp_bit;
`ifdef SNA_RESP_BOXER_PARITY_EN
    exp_bit = 1'b1;
`else
    exp_bit = 1'b0;
`endif
    rdata = 32'h0000_0007; rresp = 2'b00; dest_id = 4'h2; rvalid = 1'b1;
    #1;
    tick();
    favour_wr = 1'b1;
    rvalid = 1'b0;
    drain(0, f0, f1, ok);
    checks++;
    if (!ok || f1[34] !== exp_bit || f1 !== exp_pay(32'h7)) begin
      errors++;
      $display("FAIL parity: ok=%b payload=%h bit34=%b, want %h bit34=%b",
               ok, f1, f1[34], exp_pay(32'h7), exp_bit);
    end
  endtask

  task automatic test_random();
    logic [36:0] f0, f1, eh, ep;
    bit ok, rv, bv, gw;
    for (int i = 0; i < 40; i++) begin
      rv = 1'($urandom); bv = 1'($urandom);
      if (!rv && !bv) rv = 1'b1;
      rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom); dest_id = 4'($urandom);
      rvalid = rv; bvalid = bv;
      gw = (rv && bv) ? favour_wr : bv;
      #1;
      checks++;
      if (bready !== gw || rready !== !gw) begin
        errors++;
        $display("FAIL rand_grant[%0d]: rv=%b bv=%b bready=%b rready=%b, want %b/%b",
                 i, rv, bv, bready, rready, gw, !gw);
      end
      eh = exp_head(gw, gw ? bresp : rresp, dest_id);
      ep = exp_pay(gw ? {30'b0, bresp} : rdata);
      tick();
      favour_wr = !gw;
      rvalid = 1'b0; bvalid = 1'b0;
      drain(3, f0, f1, ok);
      checks++;
      if (!ok || f0 !== eh || f1 !== ep) begin
        errors++;
        $display("FAIL rand_flits[%0d]: ok=%b got %h/%h, want %h/%h", i, ok, f0, f1, eh, ep);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rvalid = 1'b0; bvalid = 1'b0; noc_ready = 1'b0;
    rdata = '0; rresp = '0; bresp = '0; dest_id = '0;
    test_reset();
    test_tie_rr();
    test_read_latency();
    test_write();
    test_stall();
    test_reset_mid();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
